// File: rtl/hls_wdg_pkg.sv
// Shared types, default widths and saturating-increment helper for the HLS deadlock watchdog.
package hls_wdg_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } wdgState_e;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_TS_W  = 32;
  localparam int DEF_EVT_W = 8;

  // Callers zero-extend into 64 bits and cast the result back to their own width.
  function automatic logic [63:0] satInc(input logic [63:0] value, input int unsigned width);
    logic [63:0] allOnes;
    allOnes = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= allOnes) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/hls_wdg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module hls_wdg_sat_counter
  import hls_wdg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock_i,
  input  logic         reset_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = W'(satInc(64'(count_q), W));
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hls_deadlock_watchdog.sv
// Qualifies a persistent upstream block condition into a sticky, timestamped deadlock event.
// Optional auto-recovery from DEADLOCK is built when DEADLOCK_AUTO_RECOVER_EN is defined.
module hls_deadlock_watchdog
  import hls_wdg_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TS_W  = DEF_TS_W,
  parameter int EVT_W = DEF_EVT_W
`ifdef DEADLOCK_AUTO_RECOVER_EN
  ,
  parameter int RECOVER_CYCLES = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             block_in,
  input  logic [CNT_W-1:0] threshold,
  input  logic             clear,
  output logic             suspect,
  output logic             deadlock,
  output logic             irq,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [TS_W-1:0]  deadlock_ts,
  output logic [EVT_W-1:0] deadlock_count
);

  wdgState_e        state_q, state_d;
  logic             suspect_q, deadlock_q, irq_q;
  logic [TS_W-1:0]  ts_q, capTs_q;
  logic [CNT_W-1:0] effThr, stallNxt;
  logic             blocked, entry, stallInc, stallClr, recExit;

  assign blocked  = enable & block_in;
  assign effThr   = (threshold == '0) ? CNT_W'(1) : threshold;
  assign stallNxt = CNT_W'(satInc(64'(stall_cycles), CNT_W));

`ifdef DEADLOCK_AUTO_RECOVER_EN
  localparam int REC_W = $clog2(RECOVER_CYCLES + 1);

  logic [REC_W-1:0] recCnt;
  logic             recClr;

  // Counts consecutive unblocked cycles spent in DEADLOCK; anything else restarts it.
  assign recExit = (state_q == DEADLOCK) && !block_in && (recCnt == REC_W'(RECOVER_CYCLES - 1));
  assign recClr  = clear | (state_q != DEADLOCK) | block_in | recExit;

  hls_wdg_sat_counter #(.W(REC_W)) u_recCnt (
    .clock_i (clock),
    .reset_ni(reset),
    .clr_i   (recClr),
    .inc_i   (1'b1),
    .count_o (recCnt)
  );
`else
  assign recExit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    entry    = 1'b0;
    stallInc = 1'b0;
    stallClr = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      stallClr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (blocked) begin
            stallInc = 1'b1;
            if (effThr == CNT_W'(1)) begin
              state_d = DEADLOCK;
              entry   = 1'b1;
            end else begin
              state_d = SUSPECT;
            end
          end else begin
            stallClr = 1'b1;
          end
        end
        SUSPECT: begin
          if (!blocked) begin
            state_d  = IDLE;
            stallClr = 1'b1;
          end else begin
            stallInc = 1'b1;
            // Also catches a threshold lowered below the running count.
            if (stallNxt >= effThr) begin
              state_d = DEADLOCK;
              entry   = 1'b1;
            end
          end
        end
        DEADLOCK: begin
          if (recExit) begin
            state_d  = IDLE;
            stallClr = 1'b1;
          end else begin
            stallInc = block_in;
          end
        end
        default: begin
          state_d  = IDLE;
          stallClr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      suspect_q  <= 1'b0;
      deadlock_q <= 1'b0;
      irq_q      <= 1'b0;
      ts_q       <= '0;
      capTs_q    <= '0;
    end else begin
      state_q    <= state_d;
      suspect_q  <= (state_d == SUSPECT);
      deadlock_q <= (state_d == DEADLOCK);
      irq_q      <= entry;
      ts_q       <= ts_q + TS_W'(1);
      if (entry) begin
        capTs_q <= ts_q;
      end
    end
  end

  hls_wdg_sat_counter #(.W(CNT_W)) u_stallCnt (
    .clock_i (clock),
    .reset_ni(reset),
    .clr_i   (stallClr),
    .inc_i   (stallInc),
    .count_o (stall_cycles)
  );

  hls_wdg_sat_counter #(.W(EVT_W)) u_evtCnt (
    .clock_i (clock),
    .reset_ni(reset),
    .clr_i   (1'b0),
    .inc_i   (entry),
    .count_o (deadlock_count)
  );

  assign suspect     = suspect_q;
  assign deadlock    = deadlock_q;
  assign irq         = irq_q;
  assign deadlock_ts = capTs_q;

endmodule
